// File: rtl/accel_pkg.sv
// Shared encodings and widths for the quantisation scheduler and its datapath.
// Pure declarations: no latency, no flow control.
package accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic MODE_88 = 1'b0;
    localparam logic MODE_18 = 1'b1;

    localparam int LANE_NUM     = 64;
    localparam int ACC_W        = 40;
    localparam int VEC_IN_W     = LANE_NUM * ACC_W;
    localparam int VEC_OUT_W    = LANE_NUM * 8;
    localparam int SCALE_ADDR_W = 6;

endpackage

// File: rtl/relu_scale_vecOp.sv
// Per-lane ReLU + logical right shift + truncate to 8 bits; purely combinational.
// Upper half of the lanes uses the second shift byte in 1x8 mode and is zero in 8x8 mode.
module relu_scale_vecOp
    import accel_pkg::*;
#(
    parameter int lane_num     = 64,
    parameter int mult_P_width = 40,
    parameter int scale_width  = 8
) (
    input  logic [lane_num*mult_P_width-1:0] in_vector,
    input  logic                             mode,
    input  logic [2*scale_width-1:0]         scale,
    output logic [lane_num*8-1:0]            out_vector
);

    for (genvar i = 0; i < lane_num; i++) begin : g_lane
        logic [mult_P_width-1:0] lane;
        logic [scale_width-1:0]  sh;
        logic                    en;

        assign lane = in_vector[i*mult_P_width +: mult_P_width];

        if (i < lane_num / 2) begin : g_lo
            assign sh = scale[scale_width-1:0];
            assign en = 1'b1;
        end else begin : g_hi
            assign sh = scale[2*scale_width-1:scale_width];
            assign en = (mode == MODE_18);
        end

        assign out_vector[i*8 +: 8] = (en && !lane[mult_P_width-1]) ? 8'(lane >> sh) : 8'd0;
    end

endmodule

// File: rtl/quant_scale_sched.sv
// Walks groups x tiles, loads a per-group shift pair, quantises accepted vectors; latency 1.
// in_ready drops while a registered output is stalled; out_vector holds until out_ready.
module quant_scale_sched
    import accel_pkg::*;
#(
    parameter int column_num_in_sa = 16,
    parameter int mult_P_width     = 40,
    parameter int scale_width      = 8,
    parameter int scale_depth      = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cfg_we,
    input  logic [SCALE_ADDR_W-1:0]                 cfg_addr,
    input  logic [2*scale_width-1:0]                cfg_wdata,
    input  logic                                    start,
    input  logic                                    mode,
    input  logic [6:0]                              group_num,
    input  logic [7:0]                              tiles_per_group,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [column_num_in_sa*4*mult_P_width-1:0] in_vector,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [column_num_in_sa*4*8-1:0]         out_vector,
    output logic                                    busy,
    output logic                                    done
);

    localparam int LANES = column_num_in_sa * 4;

    state_e                   state, state_nxt;
    logic                     mode_q;
    logic [6:0]               gn_q;
    logic [7:0]               tpg_q;
    logic [6:0]               g;
    logic [7:0]               t;
    logic [2*scale_width-1:0] scale_reg;
    logic [2*scale_width-1:0] scale_table [scale_depth];
    logic [LANES*8-1:0]       quant;
    logic                     accept;
    logic                     last_tile;
    logic                     last_group;

    assign accept     = in_valid && in_ready;
    assign last_tile  = (t == tpg_q - 8'd1);
    assign last_group = (g == gn_q - 7'd1);

    // Table is deliberately not reset; writes land at the edge that also samples start,
    // so LOAD on the following cycle already sees them.
    always_ff @(posedge clk) begin
        if (cfg_we && state == ST_IDLE) begin
            scale_table[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (group_num == 7'd0 || tiles_per_group == 8'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD:  state_nxt = ST_RUN;
            ST_RUN: begin
                in_ready = !out_valid || out_ready;
                if (accept && last_tile) begin
                    state_nxt = last_group ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_88;
            gn_q      <= '0;
            tpg_q     <= '0;
            g         <= '0;
            t         <= '0;
            scale_reg <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                mode_q <= mode;
                gn_q   <= group_num;
                tpg_q  <= tiles_per_group;
                g      <= '0;
                t      <= '0;
            end
            if (state == ST_LOAD) begin
                scale_reg <= scale_table[g[SCALE_ADDR_W-1:0]];
            end
            if (accept) begin
                if (last_tile) begin
                    t <= '0;
                    if (!last_group) begin
                        g <= g + 7'd1;
                    end
                end else begin
                    t <= t + 8'd1;
                end
            end
        end
    end

    relu_scale_vecOp #(
        .lane_num     (LANES),
        .mult_P_width (mult_P_width),
        .scale_width  (scale_width)
    ) u_vec_op (
        .in_vector  (in_vector),
        .mode       (mode_q),
        .scale      (scale_reg),
        .out_vector (quant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_vector <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_vector <= quant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quant_scale_sched.sv
// Bench for quant_scale_sched: directed vector table, corner-case sequences, random jobs vs. model.
module tb_quant_scale_sched;
    import accel_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [5:0]    cfg_addr;
    logic [15:0]   cfg_wdata;
    logic          start;
    logic          mode;
    logic [6:0]    group_num;
    logic [7:0]    tiles_per_group;
    logic          in_valid;
    logic          in_ready;
    logic [2559:0] in_vector;
    logic          out_valid;
    logic          out_ready;
    logic [511:0]  out_vector;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] mdl_table [64];

    quant_scale_sched dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .mode(mode), .group_num(group_num), .tiles_per_group(tiles_per_group),
        .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
        .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: each 40-bit lane read as an unsigned number; negative (>= 2^39) -> 0,
    // otherwise divide by 2^shift and keep the value modulo 256.
    function automatic logic [511:0] ref_vec(input logic [2559:0] v, input logic m, input logic [15:0] sc);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            longint unsigned x;
            int sh;
            x  = 64'(v[i*40 +: 40]);
            sh = (i < 32) ? int'(sc[7:0]) : int'(sc[15:8]);
            if (i >= 32 && m == 1'b0)           r[i*8 +: 8] = 8'd0;
            else if (x >= 64'h80_0000_0000)     r[i*8 +: 8] = 8'd0;
            else if (sh >= 40)                  r[i*8 +: 8] = 8'd0;
            else                                r[i*8 +: 8] = 8'((x / (64'd1 << sh)) % 256);
        end
        return r;
    endfunction

    function automatic logic [2559:0] rand_vec();
        logic [2559:0] v;
        for (int i = 0; i < 64; i++) begin
            logic [63:0] x;
            int w;
            x = {$urandom(), $urandom()};
            w = $urandom_range(1, 40);
            x = x & ((64'd1 << w) - 64'd1);
            v[i*40 +: 40] = x[39:0];
        end
        return v;
    endfunction

    task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        mdl_table[a] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_in_ready(input string nm);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) chk({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    // Random job: randomly throttled producer/consumer, illegal start/cfg noise while busy.
    task automatic run_job(input logic m, input int gn, input int tpg, input int rdy_pct, input bit noise);
        int total = gn * tpg;
        int sent = 0, loads = 0, cyc = 0, last_hs = -10, done_cyc = -1;
        bit have = 0, prev_stall = 0;
        logic [2559:0] pend = '0;
        logic [511:0] prev_vec = '0;
        logic [511:0] q[$];
        start = 1'b1; mode = m; group_num = 7'(gn); tiles_per_group = 8'(tpg);
        @(negedge clk);
        start = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            cyc++;
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (dut.state == ST_LOAD) loads++;
                if (noise) begin
                    start = ($urandom_range(0, 7) == 0);
                    group_num = 7'($urandom()); tiles_per_group = 8'($urandom());
                    cfg_we = ($urandom_range(0, 7) == 0);
                    cfg_addr = 6'($urandom_range(0, 3)); cfg_wdata = 16'($urandom());
                end
                if (!have && sent < total) begin
                    pend = rand_vec();
                    have = 1;
                end
                in_valid  = have && ($urandom_range(0, 99) < 80);
                in_vector = pend;
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                #1;
                if (prev_stall) chk("hold_vec", out_vector, prev_vec);
                if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("extra_out", 1'b1, 1'b0);
                    else chk("out_vec", out_vector, q.pop_front());
                    last_hs = cyc;
                end
                if (in_valid && in_ready) begin
                    q.push_back(ref_vec(pend, m, mdl_table[(sent / tpg) % 64]));
                    sent++;
                    have = 0;
                end
                prev_stall = out_valid && !out_ready;
                prev_vec   = out_vector;
                @(negedge clk);
            end
        end
        start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
        chk("job_done_seen", done_cyc > 0, 1'b1);
        chk("done_after_last_hs", done_cyc, last_hs + 1);
        chk("job_sent", sent, total);
        chk("job_left", q.size(), 0);
        chk("job_loads", loads, gn);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    typedef struct {
        logic [39:0] l0;
        logic [39:0] l32;
        logic        m;
        logic [15:0] sc;
        logic [7:0]  e0;
        logic [7:0]  e32;
    } tv_t;

    tv_t tv [8];

    initial begin
        logic [2559:0] va, vb, v;
        logic [511:0]  ea, eb;

        tv[0] = '{40'd1024,          40'd1024,          1'b1, 16'h0304, 8'd64,  8'd128};
        tv[1] = '{40'h80_0000_0010,  40'd500,           1'b0, 16'h0101, 8'd0,   8'd0};
        tv[2] = '{40'd4096,          40'd4096,          1'b1, 16'h0304, 8'd0,   8'd0};
        tv[3] = '{40'h00_0000_00FF,  40'h00_0000_0ABC,  1'b1, 16'h0400, 8'd255, 8'd171};
        tv[4] = '{40'h7F_FFFF_FFFF,  40'h80_0000_0000,  1'b1, 16'h2000, 8'd255, 8'd0};
        tv[5] = '{40'h12_3456_789A,  40'h12_3456_789A,  1'b1, 16'h2010, 8'd86,  8'd18};
        tv[6] = '{40'h12_3456_789A,  40'h12_3456_789A,  1'b0, 16'h2010, 8'd86,  8'd0};
        tv[7] = '{40'h7F_FFFF_FFFF,  40'h7F_FFFF_FFFF,  1'b1, 16'h2627, 8'd0,   8'd1};

        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; start = 0; mode = 0;
        group_num = 0; tiles_per_group = 0; in_valid = 0; in_vector = '0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_vector", out_vector, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single-tile jobs; cfg write shares the start cycle so LOAD must see it.
        for (int i = 0; i < 8; i++) begin
            v = '0;
            v[39:0] = tv[i].l0;
            v[32*40 +: 40] = tv[i].l32;
            cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = tv[i].sc; mdl_table[0] = tv[i].sc;
            start = 1'b1; mode = tv[i].m; group_num = 7'd1; tiles_per_group = 8'd1;
            in_valid = 1'b1; in_vector = v; out_ready = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0; start = 1'b0;
            wait_in_ready("tbl");
            @(negedge clk);
            in_valid = 1'b0;
            chk("tbl_out_valid", out_valid, 1'b1);
            chk("tbl_lane0", out_vector[7:0], tv[i].e0);
            chk("tbl_lane32", out_vector[263:256], tv[i].e32);
            chk("tbl_full", out_vector, ref_vec(v, tv[i].m, tv[i].sc));
            @(negedge clk);
            chk("tbl_done", done, 1'b1);
            @(negedge clk);
            chk("tbl_done_clear", done, 1'b0);
        end

        // Empty jobs complete straight away without opening the input.
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; group_num = (i == 0) ? 7'd2 : 7'd0; tiles_per_group = (i == 0) ? 8'd0 : 8'd3;
            @(negedge clk);
            start = 1'b0;
            chk("empty_done", done, 1'b1);
            chk("empty_in_ready", in_ready, 1'b0);
            chk("empty_busy", busy, 1'b1);
            @(negedge clk);
            chk("empty_done_clear", done, 1'b0);
            chk("empty_idle", busy, 1'b0);
        end

        // Three groups of two tiles, shifts 1,1,2,2,3,3.
        cfg_write(6'd0, 16'h0001);
        cfg_write(6'd1, 16'h0002);
        cfg_write(6'd2, 16'h0003);
        run_job(1'b0, 3, 2, 100, 1'b0);

        // Five-cycle output stall with the next vector waiting.
        cfg_write(6'd0, 16'h0202);
        va = rand_vec(); vb = rand_vec();
        ea = ref_vec(va, 1'b1, 16'h0202); eb = ref_vec(vb, 1'b1, 16'h0202);
        start = 1'b1; mode = 1'b1; group_num = 7'd1; tiles_per_group = 8'd2;
        out_ready = 1'b0; in_valid = 1'b1; in_vector = va;
        @(negedge clk);
        start = 1'b0;
        wait_in_ready("stall");
        @(negedge clk);
        in_vector = vb;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_in_ready_low", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_vec_a", out_vector, ea);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("release_valid", out_valid, 1'b1);
        chk("release_vec_b", out_vector, eb);
        @(negedge clk);
        chk("stall_job_done", done, 1'b1);
        @(negedge clk);
        chk("stall_job_idle", busy, 1'b0);

        // Reset in RUN after one of four tiles, with an output still pending.
        cfg_write(6'd0, 16'h0101);
        start = 1'b1; mode = 1'b0; group_num = 7'd1; tiles_per_group = 8'd4;
        out_ready = 1'b0; in_valid = 1'b1; in_vector = rand_vec();
        @(negedge clk);
        start = 1'b0;
        wait_in_ready("midrst");
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_pending", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_vector", out_vector, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(1'b1, 2, 3, 70, 1'b0);

        // Randomised jobs with illegal start/cfg noise while busy.
        for (int j = 0; j < 6; j++) begin
            for (int a = 0; a < 4; a++) begin
                logic [15:0] s;
                s = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
                if ($urandom_range(0, 9) == 0) s[7:0] = 8'd45;
                cfg_write(6'(a), s);
            end
            run_job(1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(30, 100), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
